// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: load/store strobes, status read-back and serial outputs of the MMIO UART transmitter.
interface mmio_uart_tx_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        sb;
    logic        sh;
    logic        sw;
    logic        load_enb;
    logic        tx;
    logic        busy;

    modport slave (
        input  address, write_data, sb, sh, sw, load_enb,
        output read_data, tx, busy
    );

    modport master (
        output address, write_data, sb, sh, sw, load_enb,
        input  read_data, tx, busy
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with TX FIFO and pollable STATUS register.
// Define UART_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input logic           clk,
    input logic           rst,
    mmio_uart_tx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        r_state, w_state_n;
    logic [BW-1:0] r_baud, w_baud_n;
    logic [2:0]    r_bit, w_bit_n;
    logic [7:0]    r_data;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic [29:0]   w_idx;
    logic [31:0]   w_status;
    logic          w_wr, w_push_req, w_push, w_pop, w_empty, w_full;
    logic          w_baud_end, w_ovf_set, w_ovf_clr, w_tx;
    logic          w_unused;

    // Word index relative to the window; out-of-window addresses wrap to large values.
    assign w_idx      = bus.address[31:2] - BASE_ADDR[31:2];
    assign w_wr       = bus.sb | bus.sh | bus.sw;
    assign w_push_req = w_wr && w_idx == 30'd0;
    assign w_ovf_clr  = w_wr && w_idx == 30'd2 && bus.write_data[0];
    assign w_empty    = r_count == '0;
    assign w_full     = r_count == CNT_FULL;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && !w_push;
    assign w_baud_end = r_baud == BAUD_MAX;
    assign w_status   = {16'b0, 8'(r_count), 4'b0, r_ovf, w_empty, w_full, r_state != IDLE};
    assign w_unused   = ^{bus.write_data[31:8], bus.address[1:0]};

    assign bus.read_data = (bus.load_enb && w_idx == 30'd1) ? w_status : 32'b0;
    assign bus.busy      = r_state != IDLE || !w_empty;
    assign bus.tx        = w_tx;

    always_comb begin
        w_tx = 1'b1;
        if (r_state == START) w_tx = 1'b0;
        if (r_state == DATA) w_tx = r_data[r_bit];
`ifdef UART_PARITY_EN
        if (r_state == PARITY) w_tx = ^r_data;
`endif
    end

    always_comb begin
        w_state_n = r_state;
        w_baud_n  = w_baud_end ? '0 : r_baud + 1'b1;
        w_bit_n   = r_bit;
        w_pop     = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_n = '0;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_n = START;
                end
            end
            START: if (w_baud_end) w_state_n = DATA;
            DATA: if (w_baud_end) begin
                w_bit_n = r_bit + 1'b1;
`ifdef UART_PARITY_EN
                if (r_bit == 3'd7) w_state_n = PARITY;
`else
                if (r_bit == 3'd7) w_state_n = STOP;
`endif
            end
`ifdef UART_PARITY_EN
            PARITY: if (w_baud_end) w_state_n = STOP;
`endif
            // Back-to-back frames: reload straight into START without an idle cycle.
            STOP: if (w_baud_end) begin
                w_pop     = !w_empty;
                w_state_n = w_empty ? IDLE : START;
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_baud  <= w_baud_n;
            r_bit   <= w_bit_n;
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) begin
                r_data <= r_mem[r_rp];
                r_rp   <= r_rp + 1'b1;
            end
            r_count <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
            r_ovf   <= w_ovf_set | (r_ovf & ~w_ovf_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_wp] <= bus.write_data[7:0];
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed checks of the MMIO UART transmitter (CLKS_PER_BIT=4, FIFO_DEPTH=8).
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int FL = 11 * CPB;
`else
    localparam int FL = 10 * CPB;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rec = 1'b0;
    logic q_tx[$];
    logic q_busy[$];
    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] bytes [10] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hA5, 8'h5A, 8'hC3, 8'h7E, 8'h99};

    mmio_uart_tx_if bus();

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Sample index j holds the line state after the j-th rising edge following rec going high.
    always @(negedge clk) begin
        if (rec) begin
            q_tx.push_back(bus.tx);
            q_busy.push_back(bus.busy);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input int kind);
        bus.address    = a;
        bus.write_data = d;
        bus.sb = kind == 0;
        bus.sh = kind == 1;
        bus.sw = kind == 2;
        @(posedge clk);
        #1;
        bus.sb = 1'b0;
        bus.sh = 1'b0;
        bus.sw = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.address  = a;
        bus.load_enb = 1'b1;
        #1;
        check(tag, bus.read_data, exp);
        bus.load_enb = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_rec();
        q_tx.delete();
        q_busy.delete();
        rec = 1'b1;
    endtask

    function automatic logic [63:0] exp_frame(input logic [7:0] b);
        logic [63:0] v = '0;
        int k = 0;
        for (int c = 0; c < CPB; c++) v[k++] = 1'b0;
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < CPB; c++) v[k++] = b[i];
`ifdef UART_PARITY_EN
        for (int c = 0; c < CPB; c++) v[k++] = ^b;
`endif
        for (int c = 0; c < CPB; c++) v[k++] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] obs(input bit sel_busy, input int off, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = sel_busy ? q_busy[off + i] : q_tx[off + i];
        return v;
    endfunction

    initial begin
        bus.address    = '0;
        bus.write_data = '0;
        bus.sb         = 1'b0;
        bus.sh         = 1'b0;
        bus.sw         = 1'b0;
        bus.load_enb   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        rd_check("rst_status", BASE + 4, 32'h4);
        check("rst_tx", bus.tx, 1'b1);
        check("rst_busy", bus.busy, 1'b0);

        wr(BASE, 32'h55, 0);
        start_rec();
        wait_cycles(FL + 5);
        rec = 1'b0;
        check("t2_idle_at_push", q_tx[0], 1'b1);
        check("t2_latency", q_tx[1], 1'b0);
        check("t2_frame", obs(0, 1, FL), exp_frame(8'h55));
        check("t2_busy_last", q_busy[FL], 1'b1);
        check("t2_busy_drop", q_busy[FL + 1], 1'b0);

        // Ten back-to-back stores: first pops immediately, eight queue, the tenth overflows.
        start_rec();
        for (int i = 0; i < 10; i++) begin
            bus.address    = BASE;
            bus.write_data = 32'hFFFF_FF00 | 32'(bytes[i]);
            bus.sw         = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.sw = 1'b0;
        rd_check("t3_status", BASE + 4, 32'h0000_080B);
        wait_cycles(9 * FL + 12);
        rec = 1'b0;
        for (int f = 0; f < 9; f++)
            check($sformatf("t3_frame%0d", f), obs(0, 2 + FL * f, FL), exp_frame(bytes[f]));
        check("t3_busy_last", q_busy[1 + 9 * FL], 1'b1);
        check("t3_busy_drop", q_busy[2 + 9 * FL], 1'b0);
        check("t3_no_tenth", obs(0, 2 + 9 * FL, 8), 64'hFF);

        rd_check("t4_ovf", BASE + 4, 32'hC);
        wr(BASE + 8, 32'h1, 2);
        rd_check("t4_ovf_clr", BASE + 4, 32'h4);
        start_rec();
        wr(BASE + 32'h10, 32'h12, 0);
        wr(BASE + 4, 32'h34, 0);
        wr(BASE - 4, 32'h56, 2);
        wr(BASE + 12, 32'h78, 1);
        wait_cycles(20);
        rec = 1'b0;
        check("t4_tx_quiet", obs(0, 0, 20), 64'hF_FFFF);
        check("t4_busy_quiet", obs(1, 0, 20), 64'h0);
        rd_check("t4_status", BASE + 4, 32'h4);
        rd_check("t4_rd_oor", BASE + 32'h10, 32'h0);
        bus.address = BASE + 4;
        #1;
        check("t4_no_load", bus.read_data, 32'h0);

        for (int i = 0; i < 4; i++) wr(BASE, 32'(bytes[i + 4]), 2);
        wait_cycles(10);
        rd_check("t5_pre_rst", BASE + 4, 32'h0301);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_tx_rst", bus.tx, 1'b1);
        check("t5_busy_rst", bus.busy, 1'b0);
        rd_check("t5_status_rst", BASE + 4, 32'h4);
        rst = 1'b0;
        start_rec();
        wait_cycles(50);
        rec = 1'b0;
        check("t5_tx_quiet", obs(0, 0, 48), 64'hFFFF_FFFF_FFFF);
        check("t5_busy_quiet", obs(1, 0, 48), 64'h0);

        wr(BASE, 32'h07, 0);
        start_rec();
        wait_cycles(FL + 5);
        rec = 1'b0;
        check("t6_frame", obs(0, 1, FL), exp_frame(8'h07));
        check("t6_busy_drop", q_busy[FL + 1], 1'b0);
`ifdef UART_PARITY_EN
        check("t6_parity", q_tx[1 + 9 * CPB], 1'b1);
        check("t6_stop", q_tx[1 + 10 * CPB], 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
